// File: rtl/fact_issue_queue.sv
// Operand FIFO feeding the factorial core's input handshake, with a credit
// counter that caps requests issued to the core but not yet completed.
module fact_issue_queue #(
  parameter int N       = 16,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [N-1:0]               src_data,
  output logic                       core_in_valid,
  input  logic                       core_in_ready,
  output logic [N-1:0]               core_in0,
  input  logic                       core_out_valid,
  input  logic                       core_out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(MAX_OUT):0]   inflight,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(MAX_OUT) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [IW-1:0] CAP  = IW'(MAX_OUT);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [IW-1:0] r_inflight;
  logic          r_err;

  logic w_push, w_issue, w_done;

  assign src_ready     = (r_level != FULL);
  assign core_in_valid = (r_level != '0) && (r_inflight < CAP);
  assign core_in0      = r_mem[r_rd_ptr];
  assign w_push        = src_valid & src_ready;
  assign w_issue       = core_in_valid & core_in_ready;
  assign w_done        = core_out_valid & core_out_ready;

  assign level    = r_level;
  assign inflight = r_inflight;
  assign err      = r_err;

  // Storage is never cleared; only the pointers/level define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_issue})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A completion with nothing outstanding is a protocol error, not an underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else if (w_issue && !w_done) begin
      r_inflight <= r_inflight + IW'(1);
    end else if (w_done && !w_issue) begin
      if (r_inflight != '0) r_inflight <= r_inflight - IW'(1);
      else                  r_err      <= 1'b1;
    end
  end
endmodule
